// File: rtl/max_pool_layer2.sv
// 2x2 stride-2 max pooling over a 3-channel raster stream from the conv-2 layer.
// Horizontal pairs are reduced in hmax_q; even-row results wait in a half-width line buffer.
module max_pool_layer2 #(
  parameter int unsigned FMAP_W = 10,
  parameter int unsigned FMAP_H = 10,
  parameter int unsigned DW     = 16
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                start,
  input  logic [3:1][DW-1:0]  conv_feature,
  input  logic                conv_ready,
  output logic                ready_pool,
  output logic [3:1][DW-1:0]  pool_feature,
  output logic                pool_valid,
  input  logic                next_ready,
  output logic                frame_done
);

  localparam int unsigned CW  = $clog2(FMAP_W);
  localparam int unsigned RW  = $clog2(FMAP_H);
  localparam int unsigned LW  = FMAP_W / 2;
  localparam int unsigned LIW = (LW > 1) ? $clog2(LW) : 1;

  typedef enum logic [1:0] {StIdle, StEven, StOdd} state_t;

  state_t               state_q;
  logic [CW-1:0]        col_q;
  logic [RW-1:0]        row_q;
  logic [3:1][DW-1:0]   hmax_q;
  logic [3:1][DW-1:0]   lbuf_q [LW];

  logic                 accept;
  logic                 last_col;
  logic                 last_row;
  logic                 load;
  logic [LIW-1:0]       lidx;
  logic [3:1][DW-1:0]   hpair;
  logic [3:1][DW-1:0]   win;

  assign ready_pool = (state_q != StIdle) && !(pool_valid && !next_ready);
  // A sample presented on the start cycle is dropped.
  assign accept     = conv_ready && ready_pool && !start;
  assign last_col   = (col_q == CW'(FMAP_W - 1));
  assign last_row   = (row_q == RW'(FMAP_H - 1));
  assign load       = accept && (state_q == StOdd) && col_q[0];
  assign lidx       = LIW'(col_q >> 1);

  always_comb begin
    hpair = '0;
    win   = '0;
    for (int ch = 1; ch <= 3; ch++) begin
      hpair[ch] = ($signed(conv_feature[ch]) > $signed(hmax_q[ch])) ? conv_feature[ch]
                                                                     : hmax_q[ch];
      win[ch]   = ($signed(lbuf_q[lidx][ch]) > $signed(hpair[ch])) ? lbuf_q[lidx][ch]
                                                                   : hpair[ch];
    end
  end

  // Line buffer is never read before the even row above has overwritten it.
  always_ff @(posedge clk) begin
    if (accept && (state_q == StEven) && col_q[0]) begin
      lbuf_q[lidx] <= hpair;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      hmax_q       <= '0;
      pool_feature <= '0;
      pool_valid   <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        pool_feature <= win;
        pool_valid   <= 1'b1;
        frame_done   <= last_col && last_row;
      end else if (next_ready) begin
        pool_valid <= 1'b0;
      end

      if (start) begin
        state_q <= StEven;
        col_q   <= '0;
        row_q   <= '0;
      end else if (state_q == StIdle) begin
        state_q <= StEven;
      end else if (accept) begin
        if (!col_q[0]) begin
          hmax_q <= conv_feature;
        end
        if (last_col) begin
          col_q   <= '0;
          row_q   <= last_row ? '0 : row_q + RW'(1);
          state_q <= (state_q == StEven) ? StOdd : StEven;
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_max_pool_layer2.sv
// Scoreboard bench for max_pool_layer2: a frame-level reference model pushes expected
// pooled pixels; a negedge monitor pops and compares on every downstream transfer.
module tb_max_pool_layer2;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 16;
  localparam int NP = W * H;

  typedef struct packed {
    logic               last;
    logic [3:1][DW-1:0] c;
  } exp_t;

  logic               clk = 1'b0;
  logic               n_reset;
  logic               start;
  logic [3:1][DW-1:0] conv_feature;
  logic               conv_ready;
  logic               ready_pool;
  logic [3:1][DW-1:0] pool_feature;
  logic               pool_valid;
  logic               next_ready;
  logic               frame_done;

  exp_t                 exp_q[$];
  logic signed [DW-1:0] frm [NP][3];
  int n_checks = 0;
  int n_err    = 0;
  int fd_cnt   = 0;
  int fd_exp   = 0;

  max_pool_layer2 #(.FMAP_W(W), .FMAP_H(H), .DW(DW)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .start        (start),
    .conv_feature (conv_feature),
    .conv_ready   (conv_ready),
    .ready_pool   (ready_pool),
    .pool_feature (pool_feature),
    .pool_valid   (pool_valid),
    .next_ready   (next_ready),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: each window's max taken directly from the whole stored frame.
  task automatic build_expect();
    for (int wr = 0; wr < H / 2; wr++) begin
      for (int wc = 0; wc < W / 2; wc++) begin
        exp_t e;
        e = '0;
        for (int ch = 0; ch < 3; ch++) begin
          logic signed [DW-1:0] m;
          m = frm[(2 * wr) * W + 2 * wc][ch];
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
              if (frm[(2 * wr + dy) * W + 2 * wc + dx][ch] > m)
                m = frm[(2 * wr + dy) * W + 2 * wc + dx][ch];
          e.c[ch + 1] = m;
        end
        e.last = (wr == H / 2 - 1) && (wc == W / 2 - 1);
        exp_q.push_back(e);
        if (e.last) fd_exp++;
      end
    end
  endtask

  task automatic fill_seq();
    for (int i = 0; i < NP; i++) begin
      frm[i][0] = 16'(i + 1);
      frm[i][1] = 16'(i - 16);
      frm[i][2] = 16'($urandom);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NP; i++)
      for (int ch = 0; ch < 3; ch++) frm[i][ch] = 16'($urandom);
  endtask

  task automatic send_frame(input int nsamp, input int gap_pct);
    for (int i = 0; i < nsamp; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        conv_ready = 1'b0;
        @(posedge clk); #1;
      end
      conv_feature = {frm[i][2], frm[i][1], frm[i][0]};
      conv_ready   = 1'b1;
      begin
        bit acc;
        int t;
        acc = 1'b0;
        t   = 0;
        while (!acc) begin
          @(negedge clk);
          acc = ready_pool;
          @(posedge clk); #1;
          t++;
          if (!acc && t > 500) begin
            check("accept_timeout", 0, 1);
            acc = 1'b1;
          end
        end
      end
    end
    conv_ready = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic stall_check();
    int t = 0;
    logic [3:1][DW-1:0] cap;
    @(negedge clk);
    while (!pool_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("stall_first_valid", pool_valid, 1);
    cap = pool_feature;
    repeat (6) begin
      @(negedge clk);
      check("stall_valid_held", pool_valid, 1);
      check("stall_ready_low", ready_pool, 0);
      check("stall_value_stable", pool_feature, cap);
    end
    @(posedge clk); #1;
    next_ready = 1'b1;
  endtask

  always @(negedge clk) begin
    if (n_reset) begin
      if (frame_done) begin
        fd_cnt++;
        check("frame_done_on_last", (exp_q.size() > 0) && exp_q[0].last, 1);
        check("frame_done_with_valid", pool_valid, 1);
      end
      if (pool_valid && next_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pool_feature", pool_feature, e.c);
        end
      end
    end
  end

  initial begin
    n_reset      = 1'b0;
    start        = 1'b0;
    conv_ready   = 1'b0;
    conv_feature = '0;
    next_ready   = 1'b1;
    #12;
    check("reset_ready_pool", ready_pool, 0);
    check("reset_pool_valid", pool_valid, 0);
    check("reset_pool_feature", pool_feature, 0);
    check("reset_frame_done", frame_done, 0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(negedge clk);
    check("idle_ready_pool", ready_pool, 0);
    @(posedge clk); #1;

    // Ramp on ch1, negative ramp on ch2.
    fill_seq();
    build_expect();
    send_frame(NP, 0);
    drain();

    // Downstream stall after the first result.
    fill_rand();
    build_expect();
    next_ready = 1'b0;
    fork
      send_frame(NP, 0);
      stall_check();
    join
    drain();

    // Two back-to-back random frames with input gaps.
    for (int f = 0; f < 2; f++) begin
      fill_rand();
      build_expect();
      send_frame(NP, 50);
    end
    drain();

    // Asynchronous reset partway into row 1.
    fill_rand();
    send_frame(5, 0);
    #2;
    n_reset = 1'b0;
    #1;
    check("midreset_ready_pool", ready_pool, 0);
    check("midreset_pool_valid", pool_valid, 0);
    check("midreset_pool_feature", pool_feature, 0);
    check("midreset_frame_done", frame_done, 0);
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(posedge clk); #1;
    fill_rand();
    build_expect();
    send_frame(NP, 0);
    drain();

    // Start pulse after 5 samples; the sample offered alongside it is dropped.
    fill_rand();
    send_frame(5, 0);
    start        = 1'b1;
    conv_ready   = 1'b1;
    conv_feature = {3{16'sh7fff}};
    @(posedge clk); #1;
    start      = 1'b0;
    conv_ready = 1'b0;
    fill_seq();
    build_expect();
    send_frame(NP, 0);
    drain();

    repeat (3) @(posedge clk);
    check("frame_done_count", fd_cnt, fd_exp);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
